// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps MIDI note events onto VOICE_COUNT voice slots,
// steals the oldest voice when none is free and honours the sustain pedal.
module voice_allocator #(
  parameter int VOICE_COUNT    = 8,
  parameter int NOTE_WIDTH     = 7,
  parameter int VELOCITY_WIDTH = 7
) (
  input  logic                                   clock_50_000_000,
  input  logic                                   reset,
  input  logic                                   event_valid,
  input  logic                                   event_is_on,
  input  logic [NOTE_WIDTH-1:0]                  event_note,
  input  logic [VELOCITY_WIDTH-1:0]              event_velocity,
  input  logic                                   sustain,
  input  logic [VOICE_COUNT-1:0]                 voice_envelope_end,
  output logic [VOICE_COUNT-1:0]                 voice_note_on,
  output logic [VOICE_COUNT-1:0]                 voice_note_off,
  output logic [VOICE_COUNT*NOTE_WIDTH-1:0]      voice_note,
  output logic [VOICE_COUNT*VELOCITY_WIDTH-1:0]  voice_velocity,
  output logic [VOICE_COUNT-1:0]                 voice_busy
);

  localparam int IDX_W = $clog2(VOICE_COUNT);
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(VOICE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_SUSTAINED = 2'd2,
    ST_RELEASING = 2'd3
  } voice_state_t;

  voice_state_t               r_state     [VOICE_COUNT];
  voice_state_t               w_state_nxt [VOICE_COUNT];
  logic [NOTE_WIDTH-1:0]      r_note      [VOICE_COUNT];
  logic [NOTE_WIDTH-1:0]      w_note_nxt  [VOICE_COUNT];
  logic [VELOCITY_WIDTH-1:0]  r_vel       [VOICE_COUNT];
  logic [VELOCITY_WIDTH-1:0]  w_vel_nxt   [VOICE_COUNT];
  logic [IDX_W-1:0]           r_age       [VOICE_COUNT];
  logic [IDX_W-1:0]           w_age_nxt   [VOICE_COUNT];

  logic [VOICE_COUNT-1:0] r_note_on, r_note_off, r_busy;
  logic [VOICE_COUNT-1:0] w_note_on_nxt, w_note_off_nxt, w_busy_nxt;
  logic                   r_sustain_q;

  logic             w_is_on, w_is_off, w_sus_fall;
  logic [IDX_W-1:0] w_victim;

  assign w_is_on    = event_valid & event_is_on & (event_velocity != '0);
  assign w_is_off   = event_valid & ~w_is_on;
  assign w_sus_fall = r_sustain_q & ~sustain;

  // Victim search: per-state best candidate (lowest index for IDLE, oldest otherwise).
  always_comb begin
    logic             hit_found;
    logic [IDX_W-1:0] hit_idx;
    logic [3:0]       found;
    logic [IDX_W-1:0] best_idx [4];
    logic [IDX_W-1:0] best_age [4];
    hit_found = 1'b0;
    hit_idx   = '0;
    found     = '0;
    for (int s = 0; s < 4; s++) begin
      best_idx[s] = '0;
      best_age[s] = '0;
    end
    for (int i = 0; i < VOICE_COUNT; i++) begin
      if (!hit_found && r_state[i] != ST_IDLE && r_note[i] == event_note) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!found[r_state[i]] ||
          (r_state[i] != ST_IDLE && r_age[i] > best_age[r_state[i]])) begin
        found[r_state[i]]    = 1'b1;
        best_idx[r_state[i]] = IDX_W'(i);
        best_age[r_state[i]] = r_age[i];
      end
    end
    if (hit_found)                w_victim = hit_idx;
    else if (found[ST_IDLE])      w_victim = best_idx[ST_IDLE];
    else if (found[ST_RELEASING]) w_victim = best_idx[ST_RELEASING];
    else if (found[ST_SUSTAINED]) w_victim = best_idx[ST_SUSTAINED];
    else                          w_victim = best_idx[ST_HELD];
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_note_on_nxt  = '0;
    w_note_off_nxt = '0;
    for (int i = 0; i < VOICE_COUNT; i++) begin
      w_state_nxt[i] = r_state[i];
      w_note_nxt[i]  = r_note[i];
      w_vel_nxt[i]   = r_vel[i];
      w_age_nxt[i]   = r_age[i];
      unique case (r_state[i])
        ST_RELEASING: if (voice_envelope_end[i]) w_state_nxt[i] = ST_IDLE;
        ST_HELD: begin
          if (w_is_off && r_note[i] == event_note) begin
            if (sustain) begin
              w_state_nxt[i] = ST_SUSTAINED;
            end else begin
              w_state_nxt[i]    = ST_RELEASING;
              w_note_off_nxt[i] = 1'b1;
            end
          end
        end
        ST_SUSTAINED: begin
          if (w_sus_fall) begin
            w_state_nxt[i]    = ST_RELEASING;
            w_note_off_nxt[i] = 1'b1;
          end
        end
        default: ;
      endcase
      // A note-on owns its voice outright: it overrides envelope end and release.
      if (w_is_on) begin
        if (IDX_W'(i) == w_victim) begin
          w_state_nxt[i]    = ST_HELD;
          w_note_nxt[i]     = event_note;
          w_vel_nxt[i]      = event_velocity;
          w_age_nxt[i]      = '0;
          w_note_on_nxt[i]  = 1'b1;
          w_note_off_nxt[i] = 1'b0;
        end else if (r_state[i] != ST_IDLE && r_age[i] != AGE_MAX) begin
          w_age_nxt[i] = r_age[i] + 1'b1;
        end
      end
      w_busy_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
  end

  // NOTE: the per-voice arrays are reset too, since note/velocity/age are all visible state.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      r_note_on   <= '0;
      r_note_off  <= '0;
      r_busy      <= '0;
      r_sustain_q <= 1'b0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
        r_state[i] <= ST_IDLE;
        r_note[i]  <= '0;
        r_vel[i]   <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_note_on   <= w_note_on_nxt;
      r_note_off  <= w_note_off_nxt;
      r_busy      <= w_busy_nxt;
      r_sustain_q <= sustain;
      for (int i = 0; i < VOICE_COUNT; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_note[i]  <= w_note_nxt[i];
        r_vel[i]   <= w_vel_nxt[i];
        r_age[i]   <= w_age_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < VOICE_COUNT; i++) begin
      voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]             = r_note[i];
      voice_velocity[i*VELOCITY_WIDTH +: VELOCITY_WIDTH] = r_vel[i];
    end
  end

  assign voice_note_on  = r_note_on;
  assign voice_note_off = r_note_off;
  assign voice_busy     = r_busy;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed literal scenarios plus a
// randomized run compared every cycle against a rule-level model of the voice pool.
module tb_voice_allocator;

  localparam int V  = 8;
  localparam int NW = 7;
  localparam int VW = 7;

  localparam int IDLE = 0, HELD = 1, SUS = 2, REL = 3;

  logic              clk;
  logic              reset;
  logic              event_valid, event_is_on, sustain;
  logic [NW-1:0]     event_note;
  logic [VW-1:0]     event_velocity;
  logic [V-1:0]      voice_envelope_end;
  logic [V-1:0]      voice_note_on, voice_note_off, voice_busy;
  logic [V*NW-1:0]   voice_note;
  logic [V*VW-1:0]   voice_velocity;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model of the pool: state, note, velocity, age per voice plus expected pulses.
  int       m_st [V];
  int       m_note [V];
  int       m_vel [V];
  int       m_age [V];
  bit       m_sus_prev;
  logic [V-1:0] exp_on, exp_off;

  voice_allocator #(.VOICE_COUNT(V), .NOTE_WIDTH(NW), .VELOCITY_WIDTH(VW)) dut (
    .clock_50_000_000  (clk),
    .reset             (reset),
    .event_valid       (event_valid),
    .event_is_on       (event_is_on),
    .event_note        (event_note),
    .event_velocity    (event_velocity),
    .sustain           (sustain),
    .voice_envelope_end(voice_envelope_end),
    .voice_note_on     (voice_note_on),
    .voice_note_off    (voice_note_off),
    .voice_note        (voice_note),
    .voice_velocity    (voice_velocity),
    .voice_busy        (voice_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oldest_in(input int st);
    int best = -1;
    for (int i = 0; i < V; i++)
      if (m_st[i] == st && (best < 0 || m_age[i] > m_age[best])) best = i;
    return best;
  endfunction

  task automatic model_step(input bit valid, input bit is_on, input int note, input int vel,
                            input bit sus, input logic [V-1:0] env, input bit rst);
    int  nst [V];
    int  victim;
    bit  on, off, fall;
    exp_on  = '0;
    exp_off = '0;
    if (rst) begin
      for (int i = 0; i < V; i++) begin
        m_st[i] = IDLE; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
      m_sus_prev = 1'b0;
      return;
    end
    on   = valid && is_on && (vel != 0);
    off  = valid && !on;
    fall = m_sus_prev && !sus;
    victim = -1;
    if (on) begin
      for (int i = 0; i < V; i++)
        if (victim < 0 && m_st[i] != IDLE && m_note[i] == note) victim = i;
      for (int i = 0; i < V; i++)
        if (victim < 0 && m_st[i] == IDLE) victim = i;
      if (victim < 0) victim = oldest_in(REL);
      if (victim < 0) victim = oldest_in(SUS);
      if (victim < 0) victim = oldest_in(HELD);
    end
    for (int i = 0; i < V; i++) begin
      nst[i] = m_st[i];
      if (m_st[i] == REL && env[i]) nst[i] = IDLE;
      if (off && m_st[i] == HELD && m_note[i] == note) begin
        nst[i] = sus ? SUS : REL;
        exp_off[i] = !sus;
      end
      if (fall && m_st[i] == SUS) begin
        nst[i] = REL;
        exp_off[i] = 1'b1;
      end
    end
    if (on) begin
      for (int i = 0; i < V; i++)
        if (i != victim && m_st[i] != IDLE && m_age[i] < V - 1) m_age[i]++;
      m_age[victim]   = 0;
      nst[victim]     = HELD;
      m_note[victim]  = note;
      m_vel[victim]   = vel;
      exp_on[victim]  = 1'b1;
      exp_off[victim] = 1'b0;
    end
    for (int i = 0; i < V; i++) m_st[i] = nst[i];
    m_sus_prev = sus;
  endtask

  // One clock cycle: apply inputs, advance the model at the edge, settle.
  task automatic drive(input bit valid, input bit is_on, input int note, input int vel,
                       input bit sus, input logic [V-1:0] env, input bit rst);
    reset              = rst;
    event_valid        = valid;
    event_is_on        = is_on;
    event_note         = NW'(note);
    event_velocity     = VW'(vel);
    sustain            = sus;
    voice_envelope_end = env;
    @(posedge clk);
    model_step(valid, is_on, note, vel, sus, env, rst);
    #1;
    cmp_en = 1'b1;
  endtask

  task automatic idle(input bit sus, input logic [V-1:0] env);
    drive(1'b0, 1'b0, 0, 0, sus, env, 1'b0);
  endtask

  task automatic note_on(input int note, input int vel);
    drive(1'b1, 1'b1, note, vel, 1'b0, '0, 1'b0);
  endtask

  task automatic note_off(input int note);
    drive(1'b1, 1'b0, note, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [V*NW-1:0] en;
    logic [V*VW-1:0] ev;
    logic [V-1:0]    eb;
    if (cmp_en) begin
      for (int i = 0; i < V; i++) begin
        en[i*NW +: NW] = NW'(m_note[i]);
        ev[i*VW +: VW] = VW'(m_vel[i]);
        eb[i]          = (m_st[i] != IDLE);
      end
      check("model note_on",  voice_note_on,  exp_on);
      check("model note_off", voice_note_off, exp_off);
      check("model busy",     voice_busy,     eb);
      check("model note",     voice_note,     en);
      check("model velocity", voice_velocity, ev);
      check("note_on onehot0", 64'($countones(voice_note_on) <= 1), 64'd1);
    end
  end

  initial begin
    bit r_sus;
    reset = 1'b1; event_valid = 1'b0; event_is_on = 1'b0; event_note = '0;
    event_velocity = '0; sustain = 1'b0; voice_envelope_end = '0;

    do_reset();
    do_reset();
    check("reset busy", voice_busy, 0);
    check("reset note", voice_note, 0);
    check("reset on",   voice_note_on, 0);

    // Basic on / off / envelope end on voice 0.
    note_on(60, 100);
    check("t1 on",   voice_note_on, 8'h01);
    check("t1 note", voice_note[6:0], 60);
    check("t1 vel",  voice_velocity[6:0], 100);
    check("t1 busy", voice_busy, 8'h01);
    note_off(60);
    check("t1 off",       voice_note_off, 8'h01);
    check("t1 busy rel",  voice_busy, 8'h01);
    idle(1'b0, 8'h01);
    check("t1 busy end",  voice_busy, 8'h00);
    check("t1 note kept", voice_note[6:0], 60);

    // Full pool: the oldest HELD voice is stolen without a note_off.
    do_reset();
    for (int n = 0; n < V; n++) note_on(60 + n, 80);
    note_on(70, 90);
    check("t2 on",   voice_note_on, 8'h01);
    check("t2 off",  voice_note_off, 8'h00);
    check("t2 note", voice_note[6:0], 70);
    check("t2 busy", voice_busy, 8'hFF);

    // RELEASING voice is preferred over older HELD voices.
    do_reset();
    note_on(60, 10); note_on(61, 11); note_on(62, 12);
    note_off(61);
    check("t3 off", voice_note_off, 8'h02);
    for (int n = 64; n <= 68; n++) note_on(n, 20);
    check("t3 busy", voice_busy, 8'hFF);
    note_on(63, 30);
    check("t3 on",   voice_note_on, 8'h02);
    check("t3 note", voice_note[13:7], 63);

    // Sustain holds the voice; pedal release emits the note_off.
    do_reset();
    drive(1'b1, 1'b1, 60, 50, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, 60, 0, 1'b1, '0, 1'b0);
    check("t4 no off", voice_note_off, 8'h00);
    check("t4 busy",   voice_busy, 8'h01);
    idle(1'b0, '0);
    check("t4 off",    voice_note_off, 8'h01);

    // Pedal release and matching note-off in one cycle: a single pulse.
    do_reset();
    drive(1'b1, 1'b1, 60, 50, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, 60, 0, 1'b0, '0, 1'b0);
    check("t4b off",  voice_note_off, 8'h01);
    idle(1'b0, '0);
    check("t4b once", voice_note_off, 8'h00);

    // Retrigger beats a simultaneous envelope end.
    do_reset();
    note_on(60, 40);
    note_off(60);
    drive(1'b1, 1'b1, 60, 70, 1'b0, 8'h01, 1'b0);
    check("t5 on",   voice_note_on, 8'h01);
    check("t5 busy", voice_busy, 8'h01);
    check("t5 vel",  voice_velocity[6:0], 70);

    // Velocity-0 note-on acts as note-off; unmapped note-off does nothing.
    do_reset();
    note_on(64, 50);
    note_on(64, 0);
    check("t6 vel0 off", voice_note_off, 8'h01);
    check("t6 vel0 on",  voice_note_on, 8'h00);
    note_off(90);
    check("t6 unmapped off", voice_note_off, 8'h00);
    check("t6 unmapped on",  voice_note_on, 8'h00);
    check("t6 busy",         voice_busy, 8'h01);

    // Reset mid-operation suppresses the pending note-on.
    note_on(61, 5);
    drive(1'b1, 1'b1, 62, 10, 1'b0, '0, 1'b1);
    check("t7 on",   voice_note_on, 8'h00);
    check("t7 busy", voice_busy, 8'h00);

    // Randomized run against the model.
    r_sus = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [V-1:0] env;
      int vel;
      if ($urandom_range(0, 15) == 0) r_sus = ~r_sus;
      env = V'($urandom & $urandom & $urandom);
      vel = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), 60 + int'($urandom_range(0, 11)),
            vel, r_sus, env, ($urandom_range(0, 399) == 0));
    end
    idle(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
